i2cmb_xfer_sequencer: RTL and testbench

- Hardware master that turns high-level I2C transfer requests into the I2CMB Wishbone register command sequence: enable, set bus, start, address, data bytes, stop.
- Sits between a requester (DMA/test logic) and the I2CMB Wishbone slave port. It serialises one transfer at a time and uses the I2CMB irq to detect command completion.
- Replaces software register poking in system-level runs.

---
 rtl/i2cmb_xfer_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_i2cmb_xfer_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_xfer_sequencer.sv
// i2cmb_xfer_sequencer
// Turns one high-level I2C transfer request at a time into the I2CMB Wishbone
// register sequence (enable, set bus, start, address, data bytes, stop) and
// uses the core's irq to detect completion of each byte-level command.
//
// State table:
//   state        | meaning
//   S_INIT       | write CSR=0xC0 (core enable + irq enable)
//   S_IDLE       | ready for a request
//   S_BUS_DPR    | write DPR=bus id ahead of SET_BUS
//   S_ADDR_DPR   | write DPR={addr,rw} ahead of the address byte
//   S_WAIT_WDATA | wait for a write byte from the requester
//   S_WR_DPR     | write DPR=data byte
//   S_RD_DPR     | read DPR (received byte)
//   S_CMD_WR     | write CMDR=cmd_q
//   S_CMD_WAIT   | wait for irq, timeout down-counter running
//   S_CMD_RD     | read CMDR (clears irq), decode status
//   S_TO_CSR0    | timeout recovery: CSR=0x00
//   S_TO_CSR1    | timeout recovery: CSR=0xC0
//   S_DONE       | one-cycle done pulse with status
//
// Ports:
//   clk_i, rst_n_i                       clock, synchronous active-low reset
//   req_valid_i/req_ready_o              transfer request handshake
//   req_rw_i, req_bus_id_i, req_addr_i,
//   req_len_i                            transfer description (len 0 = probe)
//   wdata_valid_i/wdata_ready_o, wdata_i write byte stream
//   rdata_valid_o, rdata_o               read byte pulse
//   done_o, status_o                     completion pulse and result code
//   wb_*                                 Wishbone master to the I2CMB slave
//   irq_i                                I2CMB interrupt
module i2cmb_xfer_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int NUM_BUSES      = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [3:0] req_bus_id_i,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_len_i,
  input  logic       wdata_valid_i,
  output logic       wdata_ready_o,
  input  logic [7:0] wdata_i,
  output logic       rdata_valid_o,
  output logic [7:0] rdata_o,
  output logic       done_o,
  output logic [2:0] status_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       irq_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] NB = 5'(NUM_BUSES);

  localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2;

  localparam logic [2:0] ST_OK = 3'd0, ST_NAK_ADDR = 3'd1, ST_NAK_DATA = 3'd2,
                         ST_ARB = 3'd3, ST_ERR = 3'd4, ST_TIMEOUT = 3'd5;

  localparam logic [2:0] C_WRITE = 3'd1, C_READ_ACK = 3'd2, C_READ_NAK = 3'd3,
                         C_START = 3'd4, C_STOP = 3'd5, C_SET_BUS = 3'd6;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_BUS_DPR, S_ADDR_DPR, S_WAIT_WDATA, S_WR_DPR, S_RD_DPR,
    S_CMD_WR, S_CMD_WAIT, S_CMD_RD, S_TO_CSR0, S_TO_CSR1, S_DONE
  } state_t;

  // Which step of the transfer the in-flight command belongs to.
  typedef enum logic [2:0] {
    PH_SETBUS, PH_START, PH_ADDR, PH_WDATA, PH_RDATA, PH_STOP
  } phase_t;

  state_t        state_q, state_n;
  phase_t        phase_q, phase_n;
  logic [2:0]    cmd_q, cmd_n;
  logic          rw_q, rw_n;
  logic [3:0]    bus_q, bus_n;
  logic [6:0]    addr_q, addr_n;
  logic [7:0]    cnt_q, cnt_n;
  logic [7:0]    wbyte_q, wbyte_n;
  logic [2:0]    st_q, st_n;
  logic [3:0]    cache_bus_q, cache_bus_n;
  logic          cache_vld_q, cache_vld_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic          gap_q, gap_n;
  logic [7:0]    rdata_q, rdata_n;
  logic          rvld_q, rvld_n;

  logic       acc, acc_we, ack_hit;
  logic [1:0] acc_adr;
  logic [7:0] acc_dat;

  // Wishbone access requested by the current state.
  always_comb begin
    acc     = 1'b0;
    acc_we  = 1'b0;
    acc_adr = A_CSR;
    acc_dat = 8'h00;
    case (state_q)
      S_INIT:     begin acc = 1'b1; acc_we = 1'b1; acc_adr = A_CSR;  acc_dat = 8'hC0; end
      S_BUS_DPR:  begin acc = 1'b1; acc_we = 1'b1; acc_adr = A_DPR;  acc_dat = {4'h0, bus_q}; end
      S_ADDR_DPR: begin acc = 1'b1; acc_we = 1'b1; acc_adr = A_DPR;  acc_dat = {addr_q, rw_q}; end
      S_WR_DPR:   begin acc = 1'b1; acc_we = 1'b1; acc_adr = A_DPR;  acc_dat = wbyte_q; end
      S_RD_DPR:   begin acc = 1'b1; acc_adr = A_DPR; end
      S_CMD_WR:   begin acc = 1'b1; acc_we = 1'b1; acc_adr = A_CMDR; acc_dat = {5'h00, cmd_q}; end
      S_CMD_RD:   begin acc = 1'b1; acc_adr = A_CMDR; end
      S_TO_CSR0:  begin acc = 1'b1; acc_we = 1'b1; acc_adr = A_CSR;  acc_dat = 8'h00; end
      S_TO_CSR1:  begin acc = 1'b1; acc_we = 1'b1; acc_adr = A_CSR;  acc_dat = 8'hC0; end
      default:    acc = 1'b0;
    endcase
  end

  // gap_q forces the idle cycle after every ack; it is also set by reset so
  // the bus stays quiet while reset is held and drops the cycle after a
  // mid-transfer reset.
  assign wb_cyc_o = acc & ~gap_q;
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = wb_cyc_o & acc_we;
  assign wb_adr_o = wb_cyc_o ? acc_adr : 2'd0;
  assign wb_dat_o = wb_cyc_o ? acc_dat : 8'h00;
  assign ack_hit  = wb_cyc_o & wb_ack_i;

  assign req_ready_o   = (state_q == S_IDLE);
  assign wdata_ready_o = (state_q == S_WAIT_WDATA) & wdata_valid_i;
  assign done_o        = (state_q == S_DONE);
  assign status_o      = done_o ? st_q : 3'd0;
  assign rdata_valid_o = rvld_q;
  assign rdata_o       = rdata_q;

  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    cmd_n       = cmd_q;
    rw_n        = rw_q;
    bus_n       = bus_q;
    addr_n      = addr_q;
    cnt_n       = cnt_q;
    wbyte_n     = wbyte_q;
    st_n        = st_q;
    cache_bus_n = cache_bus_q;
    cache_vld_n = cache_vld_q;
    tmr_n       = tmr_q;
    gap_n       = ack_hit;
    rdata_n     = rdata_q;
    rvld_n      = 1'b0;

    case (state_q)
      S_INIT: if (ack_hit) state_n = S_IDLE;

      S_IDLE: begin
        if (req_valid_i) begin
          rw_n   = req_rw_i;
          bus_n  = req_bus_id_i;
          addr_n = req_addr_i;
          cnt_n  = req_len_i;
          st_n   = ST_OK;
          if ({1'b0, req_bus_id_i} >= NB) begin
            st_n    = ST_ERR;
            state_n = S_DONE;
          end else if (cache_vld_q && cache_bus_q == req_bus_id_i) begin
            cmd_n   = C_START;
            phase_n = PH_START;
            state_n = S_CMD_WR;
          end else begin
            state_n = S_BUS_DPR;
          end
        end
      end

      S_BUS_DPR: if (ack_hit) begin
        cmd_n = C_SET_BUS; phase_n = PH_SETBUS; state_n = S_CMD_WR;
      end

      S_ADDR_DPR: if (ack_hit) begin
        cmd_n = C_WRITE; phase_n = PH_ADDR; state_n = S_CMD_WR;
      end

      S_WAIT_WDATA: if (wdata_valid_i) begin
        wbyte_n = wdata_i;
        state_n = S_WR_DPR;
      end

      S_WR_DPR: if (ack_hit) begin
        cmd_n = C_WRITE; phase_n = PH_WDATA; state_n = S_CMD_WR;
      end

      S_RD_DPR: if (ack_hit) begin
        rdata_n = wb_dat_i;
        rvld_n  = 1'b1;
        cnt_n   = cnt_q - 8'd1;
        state_n = S_CMD_WR;
        if (cnt_q == 8'd1) begin
          cmd_n = C_STOP; phase_n = PH_STOP;
        end else begin
          // cnt_q still counts the byte just received
          cmd_n   = (cnt_q > 8'd2) ? C_READ_ACK : C_READ_NAK;
          phase_n = PH_RDATA;
        end
      end

      S_CMD_WR: if (ack_hit) begin
        tmr_n   = TW'(TIMEOUT_CYCLES - 1);
        state_n = S_CMD_WAIT;
      end

      S_CMD_WAIT: begin
        if (irq_i) begin
          state_n = S_CMD_RD;
        end else if (tmr_q == '0) begin
          st_n    = ST_TIMEOUT;
          state_n = S_TO_CSR0;
        end else begin
          tmr_n = tmr_q - TW'(1);
        end
      end

      S_CMD_RD: if (ack_hit) begin
        if (wb_dat_i[7]) begin
          case (phase_q)
            PH_SETBUS: begin
              cache_bus_n = bus_q;
              cache_vld_n = 1'b1;
              cmd_n = C_START; phase_n = PH_START; state_n = S_CMD_WR;
            end
            PH_START: state_n = S_ADDR_DPR;
            PH_ADDR: begin
              if (cnt_q == 8'd0) begin
                cmd_n = C_STOP; phase_n = PH_STOP; state_n = S_CMD_WR;
              end else if (rw_q) begin
                cmd_n   = (cnt_q > 8'd1) ? C_READ_ACK : C_READ_NAK;
                phase_n = PH_RDATA;
                state_n = S_CMD_WR;
              end else begin
                state_n = S_WAIT_WDATA;
              end
            end
            PH_WDATA: begin
              cnt_n = cnt_q - 8'd1;
              if (cnt_q == 8'd1) begin
                cmd_n = C_STOP; phase_n = PH_STOP; state_n = S_CMD_WR;
              end else begin
                state_n = S_WAIT_WDATA;
              end
            end
            PH_RDATA: state_n = S_RD_DPR;
            default:  state_n = S_DONE;
          endcase
        end else if (wb_dat_i[6] && (phase_q == PH_ADDR || phase_q == PH_WDATA)) begin
          st_n    = (phase_q == PH_ADDR) ? ST_NAK_ADDR : ST_NAK_DATA;
          cmd_n   = C_STOP;
          phase_n = PH_STOP;
          state_n = S_CMD_WR;
        end else if (!wb_dat_i[6] && wb_dat_i[5]) begin
          st_n    = ST_ARB;
          state_n = S_DONE;
        end else begin
          // ERR, an unexpected NAK, or no status bit at all
          st_n    = ST_ERR;
          state_n = S_DONE;
          if (phase_q == PH_SETBUS) cache_vld_n = 1'b0;
        end
      end

      S_TO_CSR0: if (ack_hit) state_n = S_TO_CSR1;
      S_TO_CSR1: if (ack_hit) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_INIT;
      phase_q     <= PH_SETBUS;
      cmd_q       <= 3'd0;
      rw_q        <= 1'b0;
      bus_q       <= 4'd0;
      addr_q      <= 7'd0;
      cnt_q       <= 8'd0;
      wbyte_q     <= 8'd0;
      st_q        <= ST_OK;
      cache_bus_q <= 4'd0;
      cache_vld_q <= 1'b0;
      tmr_q       <= '0;
      gap_q       <= 1'b1;
      rdata_q     <= 8'd0;
      rvld_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      phase_q     <= phase_n;
      cmd_q       <= cmd_n;
      rw_q        <= rw_n;
      bus_q       <= bus_n;
      addr_q      <= addr_n;
      cnt_q       <= cnt_n;
      wbyte_q     <= wbyte_n;
      st_q        <= st_n;
      cache_bus_q <= cache_bus_n;
      cache_vld_q <= cache_vld_n;
      tmr_q       <= tmr_n;
      gap_q       <= gap_n;
      rdata_q     <= rdata_n;
      rvld_q      <= rvld_n;
    end
  end

endmodule

// File: tb/tb_i2cmb_xfer_sequencer.sv
// Testbench for i2cmb_xfer_sequencer: I2CMB register-level slave model,
// table of transfers with expected status, scoreboard queues for the
// Wishbone write sequence, read bytes and done status.
module tb_i2cmb_xfer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       req_valid_i, req_ready_o, req_rw_i;
  logic [3:0] req_bus_id_i;
  logic [6:0] req_addr_i;
  logic [7:0] req_len_i;
  logic       wdata_valid_i, wdata_ready_o;
  logic [7:0] wdata_i;
  logic       rdata_valid_o;
  logic [7:0] rdata_o;
  logic       done_o;
  logic [2:0] status_o;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [1:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_ack_i, irq_i;

  always #5 clk = ~clk;

  i2cmb_xfer_sequencer #(.TIMEOUT_CYCLES(100), .NUM_BUSES(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
    .req_bus_id_i(req_bus_id_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
    .done_o(done_o), .status_o(status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .irq_i(irq_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pool(input int k);
    return 8'(k * 37) ^ 8'h5A;
  endfunction

  // ---------------- scoreboard ----------------
  logic [9:0] exp_wb[$];
  logic [7:0] exp_rd[$];
  logic [2:0] exp_st[$];
  logic [7:0] wq[$];
  int         cyc_cnt = 0;
  int         t_last_cmd = 0;
  int         t_csr0 = 0;

  // ---------------- I2CMB slave model ----------------
  // flt: 0 none, 1 NAK on address, 2 AL on second data byte, 3 ERR on SET_BUS
  int         flt = 0;
  bit         no_irq = 1'b0;
  logic [7:0] cmdr_st = 8'h00;
  int         irq_dly = 0;
  bit         addr_ph = 1'b0;
  int         dcnt = 0;
  int         rd_k = 0;

  assign wb_dat_i = (wb_adr_o == 2'd2) ? cmdr_st :
                    (wb_adr_o == 2'd1) ? pool(rd_k) : 8'h00;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_ack_i;
    if (irq_dly > 0) begin
      irq_dly <= irq_dly - 1;
      if (irq_dly == 1 && !no_irq) irq_i <= 1'b1;
    end
    if (wb_ack_i && wb_cyc_o) begin
      if (wb_we_o && wb_adr_o == 2'd2) begin
        irq_dly <= 3;
        cmdr_st <= 8'h80;
        if (wb_dat_o == 8'h04) begin
          addr_ph <= 1'b1;
          dcnt    <= 0;
        end else if (wb_dat_o == 8'h06 && flt == 3) begin
          cmdr_st <= 8'h10;
        end else if (wb_dat_o == 8'h01) begin
          if (addr_ph) begin
            addr_ph <= 1'b0;
            if (flt == 1) cmdr_st <= 8'h40;
          end else begin
            dcnt <= dcnt + 1;
            if (flt == 2 && dcnt + 1 == 2) cmdr_st <= 8'h20;
          end
        end
      end
      if (!wb_we_o && wb_adr_o == 2'd2) irq_i <= 1'b0;
      if (!wb_we_o && wb_adr_o == 2'd1) rd_k <= rd_k + 1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (wb_cyc_o && wb_ack_i) begin
      chk("stb_eq_cyc", {31'd0, wb_stb_o}, 32'd1);
      if (wb_we_o) begin
        if (wb_adr_o == 2'd2) t_last_cmd = cyc_cnt;
        if (wb_adr_o == 2'd0 && wb_dat_o == 8'h00) t_csr0 = cyc_cnt;
        if (exp_wb.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected actual=%0h required=none", {wb_adr_o, wb_dat_o});
        end else begin
          chk("wb_write", {22'd0, wb_adr_o, wb_dat_o}, {22'd0, exp_wb.pop_front()});
        end
      end
    end
    if (rdata_valid_o) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL rdata_unexpected actual=%0h required=none", rdata_o);
      end else begin
        chk("rdata", {24'd0, rdata_o}, {24'd0, exp_rd.pop_front()});
      end
    end
    if (done_o) begin
      if (exp_st.size() == 0) begin
        total++; bad++;
        $display("FAIL done_unexpected actual=%0d required=none", status_o);
      end else begin
        chk("status", {29'd0, status_o}, {29'd0, exp_st.pop_front()});
      end
    end
  end

  // write-byte feeder
  always @(posedge clk) if (wdata_ready_o && wq.size() > 0) void'(wq.pop_front());
  always @(negedge clk) begin
    wdata_valid_i = (wq.size() > 0);
    wdata_i       = (wq.size() > 0) ? wq[0] : 8'h00;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        rw;
    logic [3:0]  bus;
    logic [6:0]  addr;
    logic [7:0]  len;
    logic [23:0] data;
    int          flt;
    logic [2:0]  st;
  } rec_t;

  bit         mc_vld = 1'b0;
  logic [3:0] mc_bus = 4'd0;
  int         mk = 0;

  task automatic model(input rec_t r);
    if (r.bus >= 4'd12) return;
    if (!(mc_vld && mc_bus == r.bus)) begin
      exp_wb.push_back({2'd1, 4'h0, r.bus});
      exp_wb.push_back({2'd2, 8'h06});
      if (r.flt == 3) begin
        mc_vld = 1'b0;
        return;
      end
      mc_vld = 1'b1;
      mc_bus = r.bus;
    end
    exp_wb.push_back({2'd2, 8'h04});
    exp_wb.push_back({2'd1, r.addr, r.rw});
    exp_wb.push_back({2'd2, 8'h01});
    if (r.flt == 1) begin
      exp_wb.push_back({2'd2, 8'h05});
      return;
    end
    for (int i = 0; i < int'(r.len); i++) begin
      if (!r.rw) begin
        exp_wb.push_back({2'd1, r.data[8*i +: 8]});
        exp_wb.push_back({2'd2, 8'h01});
        if (r.flt == 2 && i == 1) return;
      end else begin
        exp_wb.push_back({2'd2, (int'(r.len) - i > 1) ? 8'h02 : 8'h03});
        exp_rd.push_back(pool(mk));
        mk++;
      end
    end
    exp_wb.push_back({2'd2, 8'h05});
  endtask

  task automatic drive_req(input rec_t r);
    int n;
    n = 0;
    while (!req_ready_o && n < 400) begin @(negedge clk); n++; end
    chk("ready_before_req", {31'd0, req_ready_o}, 32'd1);
    req_rw_i     = r.rw;
    req_bus_id_i = r.bus;
    req_addr_i   = r.addr;
    req_len_i    = r.len;
    req_valid_i  = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done_o && n < 3000) begin @(negedge clk); n++; end
    if (!done_o) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
    @(negedge clk);
    chk("ready_after_done", {31'd0, req_ready_o}, 32'd1);
    chk("wb_seq_complete", exp_wb.size(), 0);
    chk("rd_seq_complete", exp_rd.size(), 0);
    wq.delete();
  endtask

  task automatic run(input rec_t r);
    flt = r.flt;
    model(r);
    exp_st.push_back(r.st);
    if (!r.rw) for (int i = 0; i < 3; i++) wq.push_back(r.data[8*i +: 8]);
    drive_req(r);
    wait_done();
    flt = 0;
  endtask

  rec_t tbl[8];

  initial begin
    rec_t r;
    int   n;
    tbl[0] = '{1'b0, 4'd2,  7'h22, 8'd2, 24'h002211, 0, 3'd0};
    tbl[1] = '{1'b1, 4'd2,  7'h22, 8'd3, 24'h000000, 0, 3'd0};
    tbl[2] = '{1'b0, 4'd2,  7'h50, 8'd1, 24'h000033, 1, 3'd1};
    tbl[3] = '{1'b0, 4'd5,  7'h10, 8'd3, 24'hD2D1D0, 2, 3'd3};
    tbl[4] = '{1'b1, 4'd5,  7'h33, 8'd0, 24'h000000, 0, 3'd0};
    tbl[5] = '{1'b0, 4'd13, 7'h11, 8'd1, 24'h000044, 0, 3'd4};
    tbl[6] = '{1'b0, 4'd7,  7'h12, 8'd1, 24'h000055, 3, 3'd4};
    tbl[7] = '{1'b0, 4'd5,  7'h10, 8'd1, 24'h000077, 0, 3'd0};

    rst_n_i = 1'b0; req_valid_i = 1'b0; req_rw_i = 1'b0; req_bus_id_i = '0;
    req_addr_i = '0; req_len_i = '0; irq_i = 1'b0; wb_ack_i = 1'b0;
    wdata_valid_i = 1'b0; wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_rvalid", {31'd0, rdata_valid_o}, 32'd0);
    exp_wb.push_back({2'd0, 8'hC0});
    rst_n_i = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // irq never arrives: 100 wait cycles, +1 to raise cyc, +1 slave ack latency
    r = '{1'b0, 4'd5, 7'h10, 8'd1, 24'h000088, 0, 3'd5};
    no_irq = 1'b1;
    exp_wb.push_back({2'd2, 8'h04});
    exp_wb.push_back({2'd0, 8'h00});
    exp_wb.push_back({2'd0, 8'hC0});
    exp_st.push_back(3'd5);
    wq.push_back(8'h88);
    drive_req(r);
    wait_done();
    chk("timeout_cycles", t_csr0 - t_last_cmd, 102);
    no_irq = 1'b0;

    // reset while waiting on the first read-byte command
    r = '{1'b1, 4'd5, 7'h25, 8'd2, 24'h000000, 0, 3'd0};
    exp_wb.push_back({2'd2, 8'h04});
    exp_wb.push_back({2'd1, 7'h25, 1'b1});
    exp_wb.push_back({2'd2, 8'h01});
    exp_wb.push_back({2'd2, 8'h02});
    drive_req(r);
    n = 0;
    while (!(wb_cyc_o && wb_ack_i && wb_we_o && wb_adr_o == 2'd2 && wb_dat_o == 8'h02)
           && n < 2000) begin
      @(negedge clk); n++;
    end
    no_irq = 1'b1;
    repeat (5) @(negedge clk);
    chk("rd_wait_reached", exp_wb.size(), 0);
    exp_wb.delete(); exp_rd.delete(); exp_st.delete();
    rst_n_i = 1'b0;
    @(negedge clk);
    chk("midrst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    repeat (2) @(negedge clk);
    mc_vld = 1'b0;
    no_irq = 1'b0;
    exp_wb.push_back({2'd0, 8'hC0});
    rst_n_i = 1'b1;
    run('{1'b0, 4'd5, 7'h10, 8'd0, 24'h000000, 0, 3'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
